// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel interface.
//   db_state_t : key debounce FSM states
//   SEG_TABLE  : active-low 7-segment codes for hex digits 0..F,
//                bit order g,f,e,d,c,b,a (bit 6 = g, bit 0 = a)
//   SEG_BLANK  : all segments off
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } db_state_t;

  // Index 15 is listed first so that SEG_TABLE[n] yields the code for digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_seg.sv
// Single hex-digit to 7-segment decoder (active-low segments).
//   nib : 4-bit digit value
//   seg : segments g,f,e,d,c,b,a (low = lit)
module hex_seg
  import panel_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/panel_iface.sv
// Front-panel interface: debounced push button, switch-entered data and
// control words, LED mirror and multi-digit hex display.
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   key_n    : raw push button (low = pressed), asynchronous
//   sw       : raw switches, sw[CTRL_W] selects data (1) or control (0) entry,
//              sw[CTRL_W-1] chooses shift (1) or replace (0) data entry
//   disp_val : value shown on the hex digits
//   step     : one-cycle pulse per debounced press
//   data_out : entered data word
//   ctrl_out : latched control word
//   led      : ctrl_out when sel=1, low bits of data_out when sel=0
//   hex      : active-low segments, digit i at [7i+6:7i]
// Build option: define PANEL_BLANK_EN to blank leading-zero digits.
module panel_iface
  import panel_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CTRL_W    = 9,
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_n,
  input  logic [CTRL_W:0]       sw,
  input  logic [DATA_W-1:0]     disp_val,
  output logic                  step,
  output logic [DATA_W-1:0]     data_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [CTRL_W-1:0]     led,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic              key_p0, key_p1;
  logic [CTRL_W:0]   sw_p0, sw_p1;
  db_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic              sel;

  // Stage p0/p1: two-flop synchronisers; key idles released (1), switches 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
    end
  end

  assign sel = sw_p1[CTRL_W];

  // Debounce FSM: a level must be stable for DB_CYCLES samples to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_p1) begin
            state <= PCHK;
            cnt   <= '0;
          end
        end
        PCHK: begin
          if (key_p1) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state <= HELD;
            step  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (key_p1) begin
            state <= RCHK;
            cnt   <= '0;
          end
        end
        RCHK: begin
          if (!key_p1) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry registers: update the cycle after step, from switches synced in the step cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      ctrl_out <= '0;
    end else if (step) begin
      if (sel) begin
        if (sw_p1[CTRL_W-1])
          data_out <= {data_out[DATA_W-9:0], sw_p1[7:0]};
        else
          data_out <= {{(DATA_W-8){1'b0}}, sw_p1[7:0]};
      end else begin
        ctrl_out <= sw_p1[CTRL_W-1:0];
      end
    end
  end

  assign led = sel ? ctrl_out : {1'b0, data_out[CTRL_W-2:0]};

  logic [7*DIGITS-1:0] seg_raw;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex_seg u_seg (
      .nib (disp_val[4*g +: 4]),
      .seg (seg_raw[7*g +: 7])
    );
  end

`ifdef PANEL_BLANK_EN
  logic lead_zero;

  // Walk down from the top digit; blank while every digit so far is zero.
  // Digit 0 is never blanked.
  always_comb begin
    hex       = seg_raw;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead_zero = lead_zero & (disp_val[4*i +: 4] == 4'd0);
      if (lead_zero)
        hex[7*i +: 7] = SEG_BLANK;
    end
  end
`else
  assign hex = seg_raw;
`endif

endmodule

// File: tb/tb_panel_iface.sv
module tb_panel_iface;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic [9:0]  sw;
  logic [15:0] disp_val;
  logic        step;
  logic [15:0] data_out;
  logic [8:0]  ctrl_out;
  logic [8:0]  led;
  logic [27:0] hex;

  int checks   = 0;
  int failures = 0;
  int step_cnt = 0;
  int base;

  localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S7 = 7'h78, S9 = 7'h10;
  localparam logic [6:0] SB = 7'h03, SF = 7'h0E, BL = 7'h7F;

  panel_iface #(
    .DATA_W    (16),
    .CTRL_W    (9),
    .DIGITS    (4),
    .DB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .sw       (sw),
    .disp_val (disp_val),
    .step     (step),
    .data_out (data_out),
    .ctrl_out (ctrl_out),
    .led      (led),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter: registers the step level seen before each edge
  always @(posedge clk) step_cnt <= step_cnt + (step ? 1 : 0);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full press and release; entry registers are updated when this returns
  task automatic press();
    key_n = 1'b0;
    tick(9);
    key_n = 1'b1;
    tick(9);
  endtask

  initial begin
    rst_n    = 1'b0;
    key_n    = 1'b1;
    sw       = 10'h000;
    disp_val = 16'h0000;
    tick(3);
    check("rst_step", 32'(step), 32'd0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ctrl", 32'(ctrl_out), 32'h0);
    check("rst_led",  32'(led), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Single press: step appears 6 edges after the first low sample
    base  = step_cnt;
    key_n = 1'b0;
    tick(6);
    check("press_early", 32'(step), 32'd0);
    tick(1);
    check("press_pulse", 32'(step), 32'd1);
    tick(1);
    check("press_one_cycle", 32'(step), 32'd0);
    tick(2);
    key_n = 1'b1;
    tick(12);
    check("press_count", 32'(step_cnt - base), 32'd1);

    // Bouncing key never qualifies
    base = step_cnt;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(2);
    end
    tick(8);
    check("bounce_no_step", 32'(step_cnt - base), 32'd0);

    // Data entry: shift 12 then 34, then replace with 5A
    sw = 10'h312;
    tick(3);
    press();
    check("shift_12", 32'(data_out), 32'h0012);
    sw = 10'h334;
    tick(3);
    press();
    check("shift_1234", 32'(data_out), 32'h1234);
    check("led_sel1_ctrl0", 32'(led), 32'h000);
    sw = 10'h25A;
    tick(3);
    press();
    check("replace_5A", 32'(data_out), 32'h005A);
    check("replace_ctrl_hold", 32'(ctrl_out), 32'h000);

    // Control entry with sel=0
    sw = 10'h1A5;
    tick(3);
    press();
    check("ctrl_1A5", 32'(ctrl_out), 32'h1A5);
    check("ctrl_data_hold", 32'(data_out), 32'h005A);
    check("led_sel0", 32'(led), 32'h05A);
    sw = 10'h200;
    tick(3);
    check("led_sel1", 32'(led), 32'h1A5);

    // Hex display
    disp_val = 16'h00B0;
    #1;
`ifdef PANEL_BLANK_EN
    check("hex_00B0", 32'(hex), 32'({BL, BL, SB, S0}));
`else
    check("hex_00B0", 32'(hex), 32'({S0, S0, SB, S0}));
`endif
    disp_val = 16'h9F27;
    #1;
    check("hex_9F27", 32'(hex), 32'({S9, SF, S2, S7}));
    disp_val = 16'h0000;
    #1;
`ifdef PANEL_BLANK_EN
    check("hex_0000", 32'(hex), 32'({BL, BL, BL, S0}));
`else
    check("hex_0000", 32'(hex), 32'({S0, S0, S0, S0}));
`endif

    // Reset while held discards the press; held key requalifies afterwards
    sw    = 10'h3C3;
    tick(3);
    key_n = 1'b0;
    tick(9);
    check("pre_rst_data", 32'(data_out), 32'h5AC3);
    rst_n = 1'b0;
    #1;
    check("hrst_step", 32'(step), 32'd0);
    check("hrst_data", 32'(data_out), 32'h0);
    check("hrst_ctrl", 32'(ctrl_out), 32'h0);
    check("hrst_led",  32'(led), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("post_rst_early", 32'(step), 32'd0);
    tick(1);
    check("post_rst_pulse", 32'(step), 32'd1);
    tick(1);
    check("post_rst_data", 32'(data_out), 32'h00C3);
    key_n = 1'b1;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
